// File: rtl/regfile_wb_sched_pkg.sv
// Shared typedefs for the register-file write-back scheduler and its extension unit.
package regfile_wb_sched_pkg;
   typedef enum logic [1:0] {SIZE_W = 2'd0, SIZE_H = 2'd1, SIZE_B = 2'd2, SIZE_BIT = 2'd3} cs_size;
   typedef enum logic {EXT_Z = 1'b0, EXT_S = 1'b1} cs_ext;
   typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2} wb_state_e;
endpackage

// File: rtl/regfile_wb_sched_ext_unit.sv
// wb_ext_unit: splits a 32-bit value into extended low/high half-words by size and signedness.
module wb_ext_unit
   import regfile_wb_sched_pkg::*;
(
   input  logic [31:0] data,
   input  cs_size      size,
   input  cs_ext       ext,
   output logic [15:0] lo,
   output logic [15:0] hi
);
   logic sx;

   always_comb begin
      lo = '0;
      hi = '0;
      sx = (ext == EXT_S);
      case (size)
         SIZE_W: begin
            lo = data[15:0];
            hi = data[31:16];
         end
         SIZE_H: begin
            lo = data[15:0];
            hi = {16{sx & data[15]}};
         end
         SIZE_B: begin
            lo = {{8{sx & data[7]}}, data[7:0]};
            hi = {16{sx & data[7]}};
         end
         default: begin
            lo = {15'b0, data[0]};
            hi = '0;
         end
      endcase
   end
endmodule

// File: rtl/regfile_wb_sched.sv
// Two-requester write-back scheduler: each 32-bit result is written as low then high half.
// Round-robin arbitration is enabled with macro REGFILE_WB_RR_ARB_EN; fixed LSU priority otherwise.
module regfile_wb_sched
   import regfile_wb_sched_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        lsu_valid_i,
   output logic        lsu_ready_o,
   input  logic [4:0]  lsu_rd_i,
   input  logic [31:0] lsu_data_i,
   input  cs_size      lsu_size_i,
   input  cs_ext       lsu_ext_i,
   input  logic        exe_valid_i,
   output logic        exe_ready_o,
   input  logic [4:0]  exe_rd_i,
   input  logic [31:0] exe_data_i,
   input  cs_size      exe_size_i,
   input  cs_ext       exe_ext_i,
   output logic        rf_write_o,
   output logic [4:0]  rf_rd_o,
   output logic        rf_h_sel_o,
   output logic [15:0] rf_data_o,
   output logic        pend_valid_o,
   output logic [4:0]  pend_rd_o
);
   wb_state_e   state, state_nxt;
   logic [4:0]  rd_q;
   logic [15:0] lo_q, hi_q, lo_ext, hi_ext;
   logic        acc_ok, lsu_win, exe_win, xfer;
   logic [31:0] sel_data;
   cs_size      sel_size;
   cs_ext       sel_ext;

   // New requests fit in IDLE and in HI, keeping one write per two cycles.
   assign acc_ok = (state == IDLE) || (state == HI);

`ifdef REGFILE_WB_RR_ARB_EN
   logic last_exe;

   always_comb begin
      lsu_win = lsu_valid_i;
      exe_win = exe_valid_i & ~lsu_valid_i;
      if (lsu_valid_i && exe_valid_i) begin
         lsu_win = last_exe;
         exe_win = ~last_exe;
      end
   end

   // Registered winner doubles as the last-grant flag; reset value means EXE, so LSU goes first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       last_exe <= 1'b1;
      else if (xfer) last_exe <= exe_win;
   end
`else
   assign lsu_win = lsu_valid_i;
   assign exe_win = exe_valid_i & ~lsu_valid_i;
`endif

   assign lsu_ready_o = acc_ok & lsu_win;
   assign exe_ready_o = acc_ok & exe_win;
   assign xfer        = lsu_ready_o | exe_ready_o;

   assign sel_data = lsu_win ? lsu_data_i : exe_data_i;
   assign sel_size = lsu_win ? lsu_size_i : exe_size_i;
   assign sel_ext  = lsu_win ? lsu_ext_i  : exe_ext_i;

   wb_ext_unit u_ext (
      .data (sel_data),
      .size (sel_size),
      .ext  (sel_ext),
      .lo   (lo_ext),
      .hi   (hi_ext)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         rd_q  <= '0;
         lo_q  <= '0;
         hi_q  <= '0;
      end else begin
         state <= state_nxt;
         if (xfer) begin
            rd_q <= lsu_win ? lsu_rd_i : exe_rd_i;
            lo_q <= lo_ext;
            hi_q <= hi_ext;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      rf_write_o   = 1'b0;
      rf_rd_o      = '0;
      rf_h_sel_o   = 1'b0;
      rf_data_o    = '0;
      pend_valid_o = 1'b0;
      pend_rd_o    = '0;
      case (state)
         IDLE: if (xfer) state_nxt = LO;
         LO: begin
            state_nxt    = HI;
            rf_write_o   = (rd_q != 5'd0);
            rf_rd_o      = rd_q;
            rf_data_o    = lo_q;
            pend_valid_o = 1'b1;
            pend_rd_o    = rd_q;
         end
         HI: begin
            state_nxt    = xfer ? LO : IDLE;
            rf_write_o   = (rd_q != 5'd0);
            rf_rd_o      = rd_q;
            rf_h_sel_o   = 1'b1;
            rf_data_o    = hi_q;
            pend_valid_o = 1'b1;
            pend_rd_o    = rd_q;
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed scenarios plus random traffic against a queue-of-halves model.
module tb_regfile_wb_sched;
   import regfile_wb_sched_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        lsu_valid_i = 1'b0, exe_valid_i = 1'b0;
   logic        lsu_ready_o, exe_ready_o;
   logic [4:0]  lsu_rd_i = '0, exe_rd_i = '0;
   logic [31:0] lsu_data_i = '0, exe_data_i = '0;
   cs_size      lsu_size_i = SIZE_W, exe_size_i = SIZE_W;
   cs_ext       lsu_ext_i = EXT_Z, exe_ext_i = EXT_Z;
   logic        rf_write_o, rf_h_sel_o, pend_valid_o;
   logic [4:0]  rf_rd_o, pend_rd_o;
   logic [15:0] rf_data_o;

   regfile_wb_sched dut (
      .clk(clk), .rst(rst),
      .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_i(lsu_rd_i),
      .lsu_data_i(lsu_data_i), .lsu_size_i(lsu_size_i), .lsu_ext_i(lsu_ext_i),
      .exe_valid_i(exe_valid_i), .exe_ready_o(exe_ready_o), .exe_rd_i(exe_rd_i),
      .exe_data_i(exe_data_i), .exe_size_i(exe_size_i), .exe_ext_i(exe_ext_i),
      .rf_write_o(rf_write_o), .rf_rd_o(rf_rd_o), .rf_h_sel_o(rf_h_sel_o),
      .rf_data_o(rf_data_o), .pend_valid_o(pend_valid_o), .pend_rd_o(pend_rd_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [4:0]  rd;
      logic        hs;
      logic [15:0] d;
   } half_t;

   half_t       q[$];
   bit          last_exe = 1'b1;
   int          checks = 0, errors = 0;
   int          lsu_grants = 0, exe_grants = 0;
   logic [15:0] hd[$];
   logic [4:0]  hp[$];
   logic        hw[$], hv[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Extend to a full 32-bit value with integer arithmetic, then split into halves.
   function automatic void ref_ext(input logic [31:0] d, input cs_size sz, input cs_ext ex,
                                   output logic [15:0] lo, output logic [15:0] hi);
      longint v;
      case (sz)
         SIZE_W:  v = d;
         SIZE_H:  begin v = d % 65536; if (ex == EXT_S && v >= 32768) v = v - 65536; end
         SIZE_B:  begin v = d % 256;   if (ex == EXT_S && v >= 128)   v = v - 256;   end
         default: v = d % 2;
      endcase
      lo = 16'(v);
      hi = 16'(v >>> 16);
   endfunction

   // One clock: drive at negedge, check outputs, advance the model, wait for next negedge.
   task automatic cycle(input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                        input cs_size ls, input cs_ext le,
                        input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                        input cs_size es, input cs_ext ee);
      half_t       e;
      bit          acc, lw, ew;
      logic [15:0] lo, hi;
      lsu_valid_i = lv; lsu_rd_i = lrd; lsu_data_i = ld; lsu_size_i = ls; lsu_ext_i = le;
      exe_valid_i = ev; exe_rd_i = erd; exe_data_i = ed; exe_size_i = es; exe_ext_i = ee;
      #1;
      e = '{wr: 1'b0, rd: 5'd0, hs: 1'b0, d: 16'd0};
      if (q.size() > 0) e = q[0];
      chk("rf_write", 32'(rf_write_o), 32'(e.wr));
      chk("rf_rd", 32'(rf_rd_o), 32'(e.rd));
      chk("rf_h_sel", 32'(rf_h_sel_o), 32'(e.hs));
      chk("rf_data", 32'(rf_data_o), 32'(e.d));
      chk("pend_valid", 32'(pend_valid_o), 32'(q.size() > 0));
      chk("pend_rd", 32'(pend_rd_o), 32'(e.rd));
      hd.push_back(rf_data_o); hp.push_back(pend_rd_o);
      hw.push_back(rf_write_o); hv.push_back(pend_valid_o);
      acc = (q.size() <= 1);
`ifdef REGFILE_WB_RR_ARB_EN
      lw = lv && (!ev || last_exe);
`else
      lw = lv;
`endif
      ew = ev && !lw;
      chk("lsu_ready", 32'(lsu_ready_o), 32'(acc && lw));
      chk("exe_ready", 32'(exe_ready_o), 32'(acc && ew));
      if (q.size() > 0) void'(q.pop_front());
      if (acc && (lw || ew)) begin
         if (lw) begin ref_ext(ld, ls, le, lo, hi); lsu_grants++; end
         else    begin ref_ext(ed, es, ee, lo, hi); exe_grants++; end
         q.push_back('{wr: ((lw ? lrd : erd) != 0), rd: (lw ? lrd : erd), hs: 1'b0, d: lo});
         q.push_back('{wr: ((lw ? lrd : erd) != 0), rd: (lw ? lrd : erd), hs: 1'b1, d: hi});
         last_exe = ew;
      end
      @(negedge clk);
   endtask

   task automatic idle_cyc();
      cycle(0, 0, 0, SIZE_W, EXT_Z, 0, 0, 0, SIZE_W, EXT_Z);
   endtask

   task automatic clear_hist();
      hd.delete(); hp.delete(); hw.delete(); hv.delete();
   endtask

   initial begin
      #2;
      chk("reset_write", 32'(rf_write_o), 32'd0);
      chk("reset_pend", 32'(pend_valid_o), 32'd0);
      chk("reset_data", 32'(rf_data_o), 32'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // LSU word write, first acceptance right after reset release
      clear_hist();
      cycle(1, 5, 32'hDEADBEEF, SIZE_W, EXT_Z, 0, 0, 0, SIZE_W, EXT_Z);
      idle_cyc(); idle_cyc(); idle_cyc();
      chk("w_lo", 32'(hd[1]), 32'hBEEF);
      chk("w_hi", 32'(hd[2]), 32'hDEAD);
      chk("w_idle", 32'(hv[3]), 32'd0);

      // EXE byte, signed then zero extension
      clear_hist();
      cycle(0, 0, 0, SIZE_W, EXT_Z, 1, 3, 32'h80, SIZE_B, EXT_S);
      idle_cyc(); idle_cyc();
      cycle(0, 0, 0, SIZE_W, EXT_Z, 1, 3, 32'h80, SIZE_B, EXT_Z);
      idle_cyc(); idle_cyc();
      chk("bs_lo", 32'(hd[1]), 32'hFF80);
      chk("bs_hi", 32'(hd[2]), 32'hFFFF);
      chk("bz_lo", 32'(hd[4]), 32'h0080);
      chk("bz_hi", 32'(hd[5]), 32'h0000);

      // Back-to-back: second request held through LO, taken in HI
      clear_hist();
      cycle(0, 0, 0, SIZE_W, EXT_Z, 1, 7, 32'h8001, SIZE_H, EXT_S);
      cycle(0, 0, 0, SIZE_W, EXT_Z, 1, 8, 32'h3, SIZE_BIT, EXT_Z);
      cycle(0, 0, 0, SIZE_W, EXT_Z, 1, 8, 32'h3, SIZE_BIT, EXT_Z);
      idle_cyc(); idle_cyc(); idle_cyc();
      chk("b2b_d", {hd[1], hd[2]}, 32'h8001FFFF);
      chk("b2b_d2", {hd[3], hd[4]}, 32'h00010000);
      chk("b2b_rd", {8'(hp[1]), 8'(hp[2]), 8'(hp[3]), 8'(hp[4])}, 32'h07070808);

      // rd=0 is accepted but never strobes the regfile
      clear_hist();
      cycle(1, 0, 32'h12345678, SIZE_W, EXT_Z, 0, 0, 0, SIZE_W, EXT_Z);
      idle_cyc(); idle_cyc();
      chk("rd0_write", {31'd0, hw[1] | hw[2]}, 32'd0);
      chk("rd0_pend", {30'd0, hv[1], hv[2]}, 32'd3);

      // Both requesters valid every cycle
      lsu_grants = 0; exe_grants = 0;
      for (int i = 0; i < 8; i++)
         cycle(1, 9, 32'hA5A5_0000 + i, SIZE_W, EXT_Z, 1, 10, 32'h5A5A_0000 + i, SIZE_W, EXT_Z);
      idle_cyc(); idle_cyc();
`ifdef REGFILE_WB_RR_ARB_EN
      chk("rr_exe_grants", 32'(exe_grants), 32'd2);
`else
      chk("fp_exe_starved", 32'(exe_grants), 32'd0);
`endif
      chk("contend_total", 32'(lsu_grants + exe_grants), 32'd4);

      // Reset in HI drops the high half
      cycle(1, 12, 32'hCAFEF00D, SIZE_W, EXT_Z, 0, 0, 0, SIZE_W, EXT_Z);
      idle_cyc();
      #1;
      chk("pre_rst_hi", {31'd0, rf_h_sel_o}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_write", 32'(rf_write_o), 32'd0);
      chk("rst_pend", 32'(pend_valid_o), 32'd0);
      chk("rst_data", 32'(rf_data_o), 32'd0);
      q.delete(); last_exe = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cycle(0, 0, 0, SIZE_W, EXT_Z, 1, 4, 32'hFFFF_FF01, SIZE_B, EXT_S);
      idle_cyc(); idle_cyc();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 2) == 0), 5'($urandom), $urandom,
               cs_size'($urandom_range(0, 3)), cs_ext'($urandom_range(0, 1)),
               ($urandom_range(0, 1) == 0), 5'($urandom), $urandom,
               cs_size'($urandom_range(0, 3)), cs_ext'($urandom_range(0, 1)));
      end
      idle_cyc(); idle_cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
